ecc_result_serializer: RTL

Output-side nibble serializer for the ECC scalar-multiplication core. It accepts a finished 32-bit result pair (kP.x, kP.y) from the arithmetic datapath over a valid/ready handshake. It then announces the result with a one-cycle `done` pulse and streams both coordinates out as 4-bit digits, least-significant digit first, on the `kPx`/`kPy` pins. It is the transmit counterpart of the nibble-serial operand interface, and it holds one pending result so the datapath can retire a second result while the first is still being shifted out.

---
 rtl/ecc_pkg.sv | 13 +
 rtl/ecc_result_serializer_if.sv | 18 +
 rtl/ecc_digit_shifter.sv | 38 +++
 rtl/ecc_result_serializer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared ECC definitions: operand widths and the result serializer state encoding.
package ecc_pkg;
    localparam int unsigned ECC_WIDTH  = 32;
    localparam int unsigned ECC_DIGIT  = 4;
    localparam int unsigned ECC_BEATS  = ECC_WIDTH / ECC_DIGIT;
    localparam int unsigned ECC_BEAT_W = $clog2(ECC_BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DONE  = 2'd1,
        SHIFT = 2'd2
    } ser_state_t;
endpackage

// File: rtl/ecc_result_serializer_if.sv
// Result handshake plus nibble-serial output pins of the ECC result serializer.
interface ecc_result_serializer_if;
    import ecc_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [ECC_WIDTH-1:0] in_x;
    logic [ECC_WIDTH-1:0] in_y;
    logic                 done;
    logic [ECC_DIGIT-1:0] kPx;
    logic [ECC_DIGIT-1:0] kPy;
    logic                 busy;

    modport master (output in_valid, in_x, in_y,
                    input  in_ready, done, kPx, kPy, busy);
    modport slave  (input  in_valid, in_x, in_y,
                    output in_ready, done, kPx, kPy, busy);
endinterface

// File: rtl/ecc_digit_shifter.sv
// Load / shift-right-by-one-digit register; its registered output is the next LSB digit,
// forced to zero when the following cycle is not a shift beat.
module ecc_digit_shifter
    import ecc_pkg::*;
#(
    parameter int unsigned WIDTH = ECC_WIDTH,
    parameter int unsigned DIGIT = ECC_DIGIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             out_en,
    input  logic [WIDTH-1:0] din,
    output logic [DIGIT-1:0] digit
);
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;

    always_comb begin
        sr_nxt = sr;
        if (load) begin
            sr_nxt = din;
        end else if (shift) begin
            sr_nxt = sr >> DIGIT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr    <= '0;
            digit <= '0;
        end else begin
            sr    <= sr_nxt;
            digit <= out_en ? sr_nxt[DIGIT-1:0] : '0;
        end
    end
endmodule

// File: rtl/ecc_result_serializer.sv
// Accepts a finished (kP.x, kP.y) pair, pulses done, then streams both coordinates
// LSB digit first; one extra result can wait in a pending slot.
module ecc_result_serializer
    import ecc_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    ecc_result_serializer_if.slave  bus
);
    localparam int unsigned WIDTH  = ECC_WIDTH;
    localparam int unsigned BEATS  = ECC_BEATS;
    localparam int unsigned BEAT_W = ECC_BEAT_W;

    ser_state_t        state, state_nxt;
    logic [BEAT_W-1:0] beat, beat_nxt;
    logic [WIDTH-1:0]  px, py;
    logic              pend_v, pend_nxt;
    logic              in_ready_q, done_q, busy_q;

    logic accept, last_beat;
    logic load_act, load_pend, act_from_pend, shift_act, out_en;
    logic [WIDTH-1:0] act_x, act_y;

    // Next-state, slot routing and shifter control
    always_comb begin
        state_nxt     = state;
        beat_nxt      = beat;
        pend_nxt      = pend_v;
        load_act      = 1'b0;
        load_pend     = 1'b0;
        act_from_pend = 1'b0;
        shift_act     = 1'b0;
        accept        = bus.in_valid && in_ready_q;
        last_beat     = (state == SHIFT) && (beat == BEAT_W'(BEATS - 1));

        case (state)
            IDLE: begin
                if (accept) begin
                    load_act  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = SHIFT;
                beat_nxt  = '0;
                load_pend = accept;
            end
            SHIFT: begin
                if (last_beat) begin
                    beat_nxt = '0;
                    if (pend_v) begin
                        act_from_pend = 1'b1;
                        pend_nxt      = 1'b0;
                        state_nxt     = DONE;
                    end else if (accept) begin
                        load_act  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    beat_nxt  = beat + BEAT_W'(1);
                    shift_act = 1'b1;
                    load_pend = accept;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (load_pend) begin
            pend_nxt = 1'b1;
        end
        out_en = (state_nxt == SHIFT);
        act_x  = act_from_pend ? px : bus.in_x;
        act_y  = act_from_pend ? py : bus.in_y;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            beat       <= '0;
            pend_v     <= 1'b0;
            px         <= '0;
            py         <= '0;
            in_ready_q <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            beat       <= beat_nxt;
            pend_v     <= pend_nxt;
            if (load_pend) begin
                px <= bus.in_x;
                py <= bus.in_y;
            end
            in_ready_q <= (state_nxt == IDLE) || !pend_nxt;
            done_q     <= (state_nxt == DONE);
            busy_q     <= (state_nxt != IDLE) || pend_nxt;
        end
    end

    ecc_digit_shifter #(.WIDTH(WIDTH), .DIGIT(ECC_DIGIT)) u_shift_x (
        .clk    (clk),
        .reset  (reset),
        .load   (load_act || act_from_pend),
        .shift  (shift_act),
        .out_en (out_en),
        .din    (act_x),
        .digit  (bus.kPx)
    );

    ecc_digit_shifter #(.WIDTH(WIDTH), .DIGIT(ECC_DIGIT)) u_shift_y (
        .clk    (clk),
        .reset  (reset),
        .load   (load_act || act_from_pend),
        .shift  (shift_act),
        .out_en (out_en),
        .din    (act_y),
        .digit  (bus.kPy)
    );

    assign bus.in_ready = in_ready_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
endmodule
